// File: rtl/microseq_ctrl.sv
// Next-address control stage ahead of Am2911 sequencer slices: microword pipeline, condition test, loop counter.
// Optional stack-depth tracker with sticky overflow/underflow flags is built when MSEQ_STACK_CHECK_EN is defined.
module microseq_ctrl #(
    parameter int unsigned CW    = 8,
    parameter int unsigned CONDS = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [3:0]       mi_op,
    input  logic [2:0]       mi_csel,
    input  logic             mi_cpol,
    input  logic [CW-1:0]    mi_cnt,
    input  logic             hold,
    input  logic [CONDS-1:0] cond,
    output logic [1:0]       seq_s,
    output logic             seq_fe_n,
    output logic             seq_pup,
    output logic             seq_re_n,
    output logic             seq_zero_n,
    output logic             seq_cin,
    output logic             seq_dsel,
    output logic             cnt_zero,
    output logic [2:0]       depth,
    output logic             stk_ovf,
    output logic             stk_unf
);

    typedef enum logic [3:0] {
        OP_JZ   = 4'd0,  OP_CONT = 4'd1,  OP_JMAP = 4'd2,  OP_CJP  = 4'd3,
        OP_CJS  = 4'd4,  OP_RFCT = 4'd5,  OP_CRTN = 4'd6,  OP_LDCT = 4'd7,
        OP_RPCT = 4'd8,  OP_PUSH = 4'd9,  OP_LDAR = 4'd10, OP_JAR  = 4'd11,
        OP_CJAR = 4'd12, OP_LOOP = 4'd13, OP_CJV  = 4'd14, OP_NOP  = 4'd15
    } op_t;

    localparam logic [1:0] SRC_PC    = 2'b00;
    localparam logic [1:0] SRC_AR    = 2'b01;
    localparam logic [1:0] SRC_STACK = 2'b10;
    localparam logic [1:0] SRC_D     = 2'b11;

    op_t           op_q;
    logic [2:0]    csel_q;
    logic          cpol_q;
    logic [CW-1:0] pcnt_q;
    logic [CW-1:0] ctr_q;

    logic          test;
    logic          ctr_nz;
    logic [1:0]    src_d;
    logic          dsel_d;
    logic          ld_ar_d;
    logic          force_zero_d;
    logic          push_d;
    logic          pop_d;
    logic          load_d;
    logic          dec_d;

    // Condition uses the registered select/polarity against the live condition inputs.
    assign test   = ((csel_q == 3'd0) ? 1'b1 : cond[csel_q]) ^ cpol_q;
    assign ctr_nz = (ctr_q != '0);

    // Microword pipeline register; hold keeps the current word for re-execution.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q   <= OP_JZ;
            csel_q <= 3'd0;
            cpol_q <= 1'b0;
            pcnt_q <= '0;
        end else if (!hold) begin
            op_q   <= op_t'(mi_op);
            csel_q <= mi_csel;
            cpol_q <= mi_cpol;
            pcnt_q <= mi_cnt;
        end
    end

    // Opcode decode into sequencer controls and counter/stack actions.
    always_comb begin
        src_d        = SRC_PC;
        dsel_d       = 1'b0;
        ld_ar_d      = 1'b0;
        force_zero_d = 1'b0;
        push_d       = 1'b0;
        pop_d        = 1'b0;
        load_d       = 1'b0;
        dec_d        = 1'b0;
        case (op_q)
            OP_JZ:   force_zero_d = 1'b1;
            OP_JMAP: begin src_d = SRC_D; dsel_d = 1'b1; end
            OP_CJP:  if (test) src_d = SRC_D;
            OP_CJS:  if (test) begin src_d = SRC_D; push_d = 1'b1; end
            OP_RFCT: begin
                if (ctr_nz) begin src_d = SRC_STACK; dec_d = 1'b1; end
                else pop_d = 1'b1;
            end
            OP_CRTN: if (test) begin src_d = SRC_STACK; pop_d = 1'b1; end
            OP_LDCT: load_d = 1'b1;
            OP_RPCT: if (ctr_nz) begin src_d = SRC_D; dec_d = 1'b1; end
            OP_PUSH: begin push_d = 1'b1; load_d = test; end
            OP_LDAR: ld_ar_d = 1'b1;
            OP_JAR:  src_d = SRC_AR;
            OP_CJAR: if (test) src_d = SRC_AR;
            OP_LOOP: begin
                if (test) pop_d = 1'b1;
                else src_d = SRC_STACK;
            end
            OP_CJV:  if (test) begin src_d = SRC_D; dsel_d = 1'b1; end
            default: ;
        endcase
        // Stall: sequencer re-presents the current address and nothing changes state.
        if (hold) begin
            src_d        = SRC_PC;
            dsel_d       = 1'b0;
            ld_ar_d      = 1'b0;
            force_zero_d = 1'b0;
            push_d       = 1'b0;
            pop_d        = 1'b0;
            load_d       = 1'b0;
            dec_d        = 1'b0;
        end
    end

    assign seq_s      = src_d;
    assign seq_fe_n   = ~(push_d | pop_d);
    assign seq_pup    = push_d;
    assign seq_re_n   = ~ld_ar_d;
    assign seq_zero_n = ~force_zero_d;
    assign seq_cin    = ~hold;
    assign seq_dsel   = dsel_d;
    assign cnt_zero   = ~ctr_nz;

    // Loop counter; load and decrement are never requested together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctr_q <= '0;
        end else if (load_d) begin
            ctr_q <= pcnt_q;
        end else if (dec_d) begin
            ctr_q <= ctr_q - CW'(1);
        end
    end

`ifdef MSEQ_STACK_CHECK_EN
    localparam logic [2:0] DEPTH_MAX = 3'd4;

    logic [2:0] depth_q;
    logic       ovf_q;
    logic       unf_q;

    // Logical depth of the 4-entry sequencer stack; flags are sticky until reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            depth_q <= 3'd0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (!hold) begin
            if (force_zero_d) begin
                depth_q <= 3'd0;
            end else if (push_d) begin
                if (depth_q == DEPTH_MAX) ovf_q <= 1'b1;
                else depth_q <= depth_q + 3'd1;
            end else if (pop_d) begin
                if (depth_q == 3'd0) unf_q <= 1'b1;
                else depth_q <= depth_q - 3'd1;
            end
        end
    end

    assign depth   = depth_q;
    assign stk_ovf = ovf_q;
    assign stk_unf = unf_q;
`else
    assign depth   = 3'd0;
    assign stk_ovf = 1'b0;
    assign stk_unf = 1'b0;
`endif

endmodule

// File: tb/tb_microseq_ctrl.sv
// Self-checking bench for microseq_ctrl: directed test-plan sequences plus a randomized run
// compared every cycle against an abstract model of the sequencer-control rules.
module tb_microseq_ctrl;

    localparam int unsigned CW    = 8;
    localparam int unsigned CONDS = 8;
    localparam int JZ = 0, CONT = 1, JMAP = 2, CJP = 3, CJS = 4, RFCT = 5, CRTN = 6, LDCT = 7;
    localparam int RPCT = 8, PUSH = 9, LDAR = 10, JAR = 11, CJAR = 12, LOOP = 13, CJV = 14, NOP = 15;
`ifdef MSEQ_STACK_CHECK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset_n;
    logic [3:0]       mi_op;
    logic [2:0]       mi_csel;
    logic             mi_cpol;
    logic [CW-1:0]    mi_cnt;
    logic             hold;
    logic [CONDS-1:0] cond;
    logic [1:0]       seq_s;
    logic             seq_fe_n, seq_pup, seq_re_n, seq_zero_n, seq_cin, seq_dsel;
    logic             cnt_zero;
    logic [2:0]       depth;
    logic             stk_ovf, stk_unf;

    microseq_ctrl #(.CW(CW), .CONDS(CONDS)) dut (
        .clock(clock), .reset_n(reset_n), .mi_op(mi_op), .mi_csel(mi_csel), .mi_cpol(mi_cpol),
        .mi_cnt(mi_cnt), .hold(hold), .cond(cond), .seq_s(seq_s), .seq_fe_n(seq_fe_n),
        .seq_pup(seq_pup), .seq_re_n(seq_re_n), .seq_zero_n(seq_zero_n), .seq_cin(seq_cin),
        .seq_dsel(seq_dsel), .cnt_zero(cnt_zero), .depth(depth), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: registered microword, loop count, stack depth and flags.
    int m_op, m_csel, m_cpol, m_pcnt, m_ctr, m_depth;
    bit m_ovf, m_unf;
    int e_s, e_fe_n, e_pup, e_re_n, e_zero_n, e_cin, e_dsel;
    bit a_push, a_pop, a_load, a_dec, a_clr;

    function automatic void model_reset();
        m_op = JZ; m_csel = 0; m_cpol = 0; m_pcnt = 0;
        m_ctr = 0; m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
    endfunction

    // What the sequencer should be told this cycle, from the opcode table.
    function automatic void predict();
        bit t;
        t = ((m_csel == 0) ? 1'b1 : cond[m_csel]) ^ (m_cpol != 0);
        e_s = 0; e_dsel = 0; e_re_n = 1; e_zero_n = 1; e_cin = 1;
        a_push = 0; a_pop = 0; a_load = 0; a_dec = 0; a_clr = 0;
        case (m_op)
            JZ:   begin e_zero_n = 0; a_clr = 1; end
            JMAP: begin e_s = 3; e_dsel = 1; end
            CJP:  if (t) e_s = 3;
            CJS:  if (t) begin e_s = 3; a_push = 1; end
            RFCT: if (m_ctr > 0) begin e_s = 2; a_dec = 1; end else a_pop = 1;
            CRTN: if (t) begin e_s = 2; a_pop = 1; end
            LDCT: a_load = 1;
            RPCT: if (m_ctr > 0) begin e_s = 3; a_dec = 1; end
            PUSH: begin a_push = 1; a_load = t; end
            LDAR: e_re_n = 0;
            JAR:  e_s = 1;
            CJAR: if (t) e_s = 1;
            LOOP: if (t) a_pop = 1; else e_s = 2;
            CJV:  if (t) begin e_s = 3; e_dsel = 1; end
            default: ;
        endcase
        if (hold) begin
            e_s = 0; e_dsel = 0; e_re_n = 1; e_zero_n = 1; e_cin = 0;
            a_push = 0; a_pop = 0; a_load = 0; a_dec = 0; a_clr = 0;
        end
        e_fe_n = (a_push || a_pop) ? 0 : 1;
        e_pup  = a_push ? 1 : 0;
    endfunction

    function automatic void model_edge();
        if (!reset_n) begin
            model_reset();
            return;
        end
        predict();
        if (hold) return;
        if (a_load) m_ctr = m_pcnt;
        else if (a_dec) m_ctr = m_ctr - 1;
        if (a_clr) m_depth = 0;
        else if (a_push) begin
            if (m_depth == 4) m_ovf = 1'b1; else m_depth = m_depth + 1;
        end else if (a_pop) begin
            if (m_depth == 0) m_unf = 1'b1; else m_depth = m_depth - 1;
        end
        m_op = int'(mi_op); m_csel = int'(mi_csel); m_cpol = int'(mi_cpol); m_pcnt = int'(mi_cnt);
    endfunction

    function automatic void chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic void compare_all();
        predict();
        chk("seq_s", int'(seq_s), e_s);
        chk("seq_fe_n", int'(seq_fe_n), e_fe_n);
        if (!hold) chk("seq_pup", int'(seq_pup), e_pup);
        chk("seq_re_n", int'(seq_re_n), e_re_n);
        chk("seq_zero_n", int'(seq_zero_n), e_zero_n);
        chk("seq_cin", int'(seq_cin), e_cin);
        chk("seq_dsel", int'(seq_dsel), e_dsel);
        chk("cnt_zero", int'(cnt_zero), (m_ctr == 0) ? 1 : 0);
        chk("depth", int'(depth), TRACK ? m_depth : 0);
        chk("stk_ovf", int'(stk_ovf), TRACK ? int'(m_ovf) : 0);
        chk("stk_unf", int'(stk_unf), TRACK ? int'(m_unf) : 0);
    endfunction

    task automatic apply(input int op, input int cs, input int cp, input int cn, input bit h,
                         input logic [CONDS-1:0] cd);
        mi_op = 4'(op); mi_csel = 3'(cs); mi_cpol = 1'(cp); mi_cnt = CW'(cn); hold = h; cond = cd;
        #2;
    endtask

    task automatic tick();
        compare_all();
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic go(input int op, input int cs, input int cp, input int cn);
        apply(op, cs, cp, cn, 1'b0, '0);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        model_reset();
        apply(CONT, 0, 0, 0, 1'b0, '0);
        chk("lit_rst_zero_n", int'(seq_zero_n), 0);
        chk("lit_rst_cin", int'(seq_cin), 1);
        chk("lit_rst_s", int'(seq_s), 0);
        chk("lit_rst_cnt_zero", int'(cnt_zero), 1);
        tick();
        reset_n = 1'b1;

        // First cycle after release still executes the reset JZ.
        apply(CONT, 0, 0, 0, 1'b0, '0);
        chk("lit_rel_zero_n", int'(seq_zero_n), 0);
        chk("lit_rel_cin", int'(seq_cin), 1);
        tick();
        apply(CONT, 0, 0, 0, 1'b0, '0);
        chk("lit_cont_s", int'(seq_s), 0);
        chk("lit_cont_zero_n", int'(seq_zero_n), 1);
        tick();

        // LDCT 3 then four RPCT: three repeats, then fall through.
        go(LDCT, 0, 0, 3);
        go(RPCT, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            apply(RPCT, 0, 0, 0, 1'b0, '0);
            chk("lit_rpct_s", int'(seq_s), 3);
            tick();
        end
        apply(CONT, 0, 0, 0, 1'b0, '0);
        chk("lit_rpct_exit_s", int'(seq_s), 0);
        chk("lit_rpct_cnt_zero", int'(cnt_zero), 1);
        tick();

        // Conditional call on cond[2]: taken, then not taken.
        go(CJS, 2, 0, 0);
        apply(CJS, 2, 0, 0, 1'b0, 8'b0000_0100);
        chk("lit_cjs_fe_n", int'(seq_fe_n), 0);
        chk("lit_cjs_pup", int'(seq_pup), 1);
        chk("lit_cjs_s", int'(seq_s), 3);
        tick();
        apply(CONT, 0, 0, 0, 1'b0, 8'b0000_0000);
        chk("lit_cjs_nt_fe_n", int'(seq_fe_n), 1);
        chk("lit_cjs_nt_s", int'(seq_s), 0);
        chk("lit_cjs_depth", int'(depth), TRACK ? 1 : 0);
        tick();
        apply(CONT, 0, 0, 0, 1'b0, '0);
        chk("lit_cjs_depth_hold", int'(depth), TRACK ? 1 : 0);
        tick();

        // Five pushes then six pops: saturate, overflow, underflow.
        go(JZ, 0, 0, 0);
        for (int i = 0; i < 5; i++) go(CJS, 0, 0, 0);
        apply(CRTN, 0, 0, 0, 1'b0, '0);
        chk("lit_stk_depth4", int'(depth), TRACK ? 4 : 0);
        chk("lit_stk_ovf0", int'(stk_ovf), 0);
        tick();
        apply(CRTN, 0, 0, 0, 1'b0, '0);
        chk("lit_stk_ovf1", int'(stk_ovf), TRACK ? 1 : 0);
        chk("lit_stk_depth_sat", int'(depth), TRACK ? 4 : 0);
        tick();
        for (int i = 0; i < 3; i++) go(CRTN, 0, 0, 0);
        apply(CRTN, 0, 0, 0, 1'b0, '0);
        chk("lit_stk_unf0", int'(stk_unf), 0);
        chk("lit_stk_depth0", int'(depth), 0);
        tick();
        apply(CONT, 0, 0, 0, 1'b0, '0);
        tick();
        apply(CONT, 0, 0, 0, 1'b0, '0);
        chk("lit_stk_unf1", int'(stk_unf), TRACK ? 1 : 0);
        chk("lit_stk_depth_end", int'(depth), 0);
        tick();

        // CJP stalled for three cycles, then executed exactly once.
        go(CJP, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            apply(CONT, 0, 0, 0, 1'b1, '1);
            chk("lit_hold_s", int'(seq_s), 0);
            chk("lit_hold_cin", int'(seq_cin), 0);
            chk("lit_hold_fe_n", int'(seq_fe_n), 1);
            tick();
        end
        apply(CONT, 0, 0, 0, 1'b0, '0);
        chk("lit_rel_cjp_s", int'(seq_s), 3);
        tick();
        apply(CONT, 0, 0, 0, 1'b0, '0);
        chk("lit_after_cjp_s", int'(seq_s), 0);
        tick();

        // Asynchronous reset in the middle of an RFCT loop.
        go(CJS, 0, 0, 0);
        go(LDCT, 0, 0, 5);
        go(RFCT, 0, 0, 0);
        go(RFCT, 0, 0, 0);
        apply(RFCT, 0, 0, 0, 1'b0, '0);
        chk("lit_rfct_s", int'(seq_s), 2);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("lit_mid_rst_zero_n", int'(seq_zero_n), 0);
        chk("lit_mid_rst_cnt_zero", int'(cnt_zero), 1);
        chk("lit_mid_rst_depth", int'(depth), 0);
        chk("lit_mid_rst_s", int'(seq_s), 0);
        #1;
        reset_n = 1'b1;
        tick();

        // Randomized microword stream with occasional stalls.
        for (int i = 0; i < 3000; i++) begin
            apply(int'($urandom_range(15)), int'($urandom_range(7)), int'($urandom_range(1)),
                  int'($urandom_range(6)), ($urandom_range(7) == 0), CONDS'($urandom));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
